// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand channel in, registered result channel out.
// The master side is the surrounding producer/consumer pair; the slave side is the ALU.
interface alu_seq_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] InA;
    logic [N-1:0] InB;
    logic         Cin;
    logic [3:0]   Op;
    logic         invA;
    logic         invB;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Out;
    logic         Ofl;
    logic         Zero;
    logic         lt;
    logic         lte;
    logic         gt;
    logic         gte;
    logic         busy;

    modport master (
        output in_valid, InA, InB, Cin, Op, invA, invB, sign, out_ready,
        input  in_ready, out_valid, Out, Ofl, Zero, lt, lte, gt, gte, busy
    );

    modport slave (
        input  in_valid, InA, InB, Cin, Op, invA, invB, sign, out_ready,
        output in_ready, out_valid, Out, Ofl, Zero, lt, lte, gt, gte, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle rotate/shift/add/logic ops plus
// iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_seq #(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_q, out_d;
    logic           ofl_q, ofl_d;
    logic [4:0]     flags_q, flags_d;
    logic [2*N-1:0] work_q, work_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic [1:0]     mop_q, mop_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   sel_a_s, sel_b_s, rev_s, sc_res_s, mc_res_s, rem_sub_s;
    logic [CW-1:0]  sh_s;
    logic [N:0]     sum_s, mul_add_s, rem_sh_s;
    logic [2*N-1:0] step_s;
    logic           sc_ofl_s, mc_ofl_s, accept_s, multi_s;

    // Packs {Zero, lt, lte, gt, gte} for a result value.
    function automatic logic [4:0] cmp_flags(input logic [N-1:0] v);
        logic z, n;
        z = (v == '0);
        n = v[N-1];
        return {z, n, n | z, ~(n | z), ~n};
    endfunction

    assign bus.in_ready  = ~rst & (state_q == S_IDLE) & (~out_valid_q | bus.out_ready);
    assign accept_s      = bus.in_valid & bus.in_ready;
    assign multi_s       = (bus.Op[3:2] == 2'b10);
    assign bus.out_valid = out_valid_q;
    assign bus.Out       = out_q;
    assign bus.Ofl       = ofl_q;
    assign {bus.Zero, bus.lt, bus.lte, bus.gt, bus.gte} = flags_q;
    assign bus.busy      = (state_q == S_RUN);

    // Single-cycle datapath on the live operands.
    always_comb begin
        sel_a_s  = bus.invA ? ~bus.InA : bus.InA;
        sel_b_s  = bus.invB ? ~bus.InB : bus.InB;
        sh_s     = sel_b_s[CW-1:0];
        sum_s    = {1'b0, sel_a_s} + {1'b0, sel_b_s} + {{N{1'b0}}, bus.Cin};
        sc_ofl_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            rev_s[i] = bus.InA[N-1-i];
        end
        case (bus.Op)
            4'b0000: sc_res_s = (sel_a_s << sh_s) | (sel_a_s >> (N - int'(sh_s)));
            4'b0001: sc_res_s = sel_a_s << sh_s;
            4'b0010: sc_res_s = $unsigned($signed(sel_a_s) >>> sh_s);
            4'b0011: sc_res_s = sel_a_s >> sh_s;
            4'b0100: begin
                sc_res_s = sum_s[N-1:0];
                sc_ofl_s = bus.sign ? ((sel_a_s[N-1] == sel_b_s[N-1]) && (sum_s[N-1] != sel_a_s[N-1]))
                                    : sum_s[N];
            end
            4'b0101: sc_res_s = sel_a_s & sel_b_s;
            4'b0110: sc_res_s = rev_s;
            4'b0111: sc_res_s = sel_a_s ^ sel_b_s;
            default: sc_res_s = '0;
        endcase
    end

    // One multiply or divide iteration on the shared 2N-bit work register.
    always_comb begin
        mul_add_s = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        rem_sh_s  = {work_q[2*N-1:N], work_q[N-1]};
        rem_sub_s = rem_sh_s[N-1:0] - opnd_q;
        if (mop_q[1] == 1'b0) begin
            step_s = {mul_add_s, work_q[N-1:1]};
        end else if (rem_sh_s >= {1'b0, opnd_q}) begin
            step_s = {rem_sub_s, work_q[N-2:0], 1'b1};
        end else begin
            step_s = {rem_sh_s[N-1:0], work_q[N-2:0], 1'b0};
        end
        case (mop_q)
            2'b00:   mc_res_s = step_s[N-1:0];
            2'b01:   mc_res_s = step_s[2*N-1:N];
            2'b10:   mc_res_s = step_s[N-1:0];
            default: mc_res_s = step_s[2*N-1:N];
        endcase
        mc_ofl_s = mop_q[1] ? (opnd_q == '0) : (step_s[2*N-1:N] != '0);
    end

    // FSM next state; an undrained result is kept unless it leaves this edge.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_d       = out_q;
        ofl_d       = ofl_q;
        flags_d     = flags_q;
        work_d      = work_q;
        opnd_d      = opnd_q;
        mop_d       = mop_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && multi_s) begin
                    state_d = S_RUN;
                    mop_d   = bus.Op[1:0];
                    cnt_d   = CW'(N - 1);
                    // Multiply iterates over the multiplier (selB); divide shifts the dividend (selA).
                    if (bus.Op[1]) begin
                        work_d = {{N{1'b0}}, sel_a_s};
                        opnd_d = sel_b_s;
                    end else begin
                        work_d = {{N{1'b0}}, sel_b_s};
                        opnd_d = sel_a_s;
                    end
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    out_d       = sc_res_s;
                    ofl_d       = sc_ofl_s;
                    flags_d     = (bus.Op[3:2] == 2'b11) ? 5'b00000 : cmp_flags(sc_res_s);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                work_d = step_s;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    out_d       = mc_res_s;
                    ofl_d       = mc_ofl_s;
                    flags_d     = cmp_flags(mc_res_s);
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ofl_q       <= 1'b0;
            flags_q     <= 5'b00000;
            work_q      <= '0;
            opnd_q      <= '0;
            mop_q       <= 2'b00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ofl_q       <= ofl_d;
            flags_q     <= flags_d;
            work_q      <= work_d;
            opnd_q      <= opnd_d;
            mop_q       <= mop_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule
